// File: rtl/ascon_out_serializer.sv
// Output serializer for the Ascon-128a encrypt wrapper. It captures one
// 128-bit ciphertext block and one 128-bit tag, then streams them as WORD_W-bit
// words. Ciphertext words go first, then tag words, each MS word first.
module ascon_out_serializer #(
  parameter int unsigned WORD_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      C_IN,
  input  logic [127:0]      T_IN,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_is_tag,
  output logic              out_last,
  output logic              busy,
  output logic [15:0]       frame_cnt
);

  localparam int unsigned NW = 128 / WORD_W;
  localparam int unsigned CW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [CW-1:0] LastIdx = CW'(NW - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StSendC = 2'd1;
  localparam logic [1:0] StSendT = 2'd2;

  if (!(WORD_W == 8 || WORD_W == 16 || WORD_W == 32 || WORD_W == 64 || WORD_W == 128))
  begin : g_bad_word_w
    $error("ascon_out_serializer: WORD_W must be 8, 16, 32, 64 or 128");
  end

  logic [1:0]     state_q, state_d;
  logic [255:0]   shreg_q, shreg_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           out_valid_q, out_valid_d;
  logic           out_is_tag_q, out_is_tag_d;
  logic           out_last_q, out_last_d;
  logic           busy_q, busy_d;
  logic [15:0]    frame_cnt_q, frame_cnt_d;

  logic capture;
  logic word_acc;
  logic cnt_at_last;

  // Ready in idle, or in the slot where the final tag word leaves this cycle.
  assign in_ready = !RST && ((state_q == StIdle) ||
                             ((state_q == StSendT) && out_last_q && out_ready));

  assign capture     = in_valid && in_ready;
  assign word_acc    = out_valid_q && out_ready;
  assign cnt_at_last = (cnt_q == LastIdx);

  // Next-state logic: load, shift on accept, field/frame transitions.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    out_valid_d  = out_valid_q;
    out_is_tag_d = out_is_tag_q;
    out_last_d   = out_last_q;
    busy_d       = busy_q;
    frame_cnt_d  = frame_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (capture) begin
          state_d      = StSendC;
          shreg_d      = {C_IN, T_IN};
          cnt_d        = '0;
          out_valid_d  = 1'b1;
          out_is_tag_d = 1'b0;
          out_last_d   = 1'b0;
          busy_d       = 1'b1;
        end
      end
      StSendC: begin
        if (word_acc) begin
          shreg_d = shreg_q << WORD_W;
          if (cnt_at_last) begin
            state_d      = StSendT;
            cnt_d        = '0;
            out_is_tag_d = 1'b1;
            // With a single word per field the first tag word is also the last.
            out_last_d   = (NW == 1);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      StSendT: begin
        if (word_acc) begin
          shreg_d = shreg_q << WORD_W;
          if (cnt_at_last) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            cnt_d       = '0;
            out_last_d  = 1'b0;
            if (capture) begin
              state_d      = StSendC;
              shreg_d      = {C_IN, T_IN};
              out_is_tag_d = 1'b0;
            end else begin
              state_d      = StIdle;
              out_valid_d  = 1'b0;
              out_is_tag_d = 1'b0;
              busy_d       = 1'b0;
            end
          end else begin
            cnt_d      = cnt_q + CW'(1);
            out_last_d = ((cnt_q + CW'(1)) == LastIdx);
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= StIdle;
      shreg_q      <= '0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_is_tag_q <= 1'b0;
      out_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_is_tag_q <= out_is_tag_d;
      out_last_q   <= out_last_d;
      busy_q       <= busy_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign out_data   = shreg_q[255 -: WORD_W];
  assign out_valid  = out_valid_q;
  assign out_is_tag = out_is_tag_q;
  assign out_last   = out_last_q;
  assign busy       = busy_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: doc/ascon_out_serializer.md
Name: ascon_out_serializer

Overview:
- Downstream stage of the registered Ascon-128a encrypt wrapper.
- Captures one 128-bit ciphertext block C and one 128-bit tag T, then streams them as WORD_W-bit words over a valid/ready interface to a narrow output port (bus, UART bridge or FIFO).
- Ciphertext words are sent first, then tag words, each most-significant word first.
- A frame counter supports system-level bookkeeping.

Parameters:
- WORD_W, 32, output word width; legal values 8, 16, 32, 64, 128 (128 % WORD_W == 0, checked by elaboration assertion).
- NW (localparam), 128/WORD_W, words per field.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous active-high reset.
- in_valid  input  1  C_IN/T_IN hold a valid result.
- in_ready  output  1  block can capture a result this cycle.
- C_IN  input  128  ciphertext from the encrypt stage.
- T_IN  input  128  tag from the encrypt stage.
- out_data  output  WORD_W  current output word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  sink accepts the word this cycle.
- out_is_tag  output  1  current word belongs to T (0 = belongs to C).
- out_last  output  1  current word is the final tag word.
- busy  output  1  a frame is in progress.
- frame_cnt  output  16  number of frames fully sent; wraps 16'hFFFF -> 0.

Behaviour:
- Reset (async, RST=1):
  - State is IDLE.
  - out_valid, out_is_tag, out_last, busy, frame_cnt and out_data are 0.
  - Shift register and word counter are cleared.
  - in_ready is forced 0 while RST=1.
- Definitions:
  - Capture = in_valid && in_ready.
  - Word accept = out_valid && out_ready.
- Three states: IDLE, SEND_C, SEND_T.
- in_ready (combinational):
  - 1 in IDLE.
  - 1 in SEND_T when out_last && out_ready (back-to-back capture).
  - 0 otherwise.
- IDLE:
  - On capture: load {C_IN, T_IN} into a 256-bit shift register and go to SEND_C.
  - On the next edge: out_valid=1, out_data = C_IN[127:128-WORD_W], word counter = 0, busy=1.
- SEND_C:
  - On each word accept: shift left by WORD_W and increment the word counter.
  - After the accept of word NW-1: go to SEND_T; out_is_tag=1 on that edge.
- SEND_T:
  - Same shifting as SEND_C.
  - out_last=1 while the counter equals NW-1.
  - On accept of the last word: frame_cnt += 1.
    - If a capture occurs in the same cycle: reload and go to SEND_C; out_valid stays 1 with no bubble.
    - Otherwise: go to IDLE with out_valid=0, busy=0, out_is_tag=0, out_last=0.
- Stall:
  - out_valid=1 && out_ready=0 holds out_data, out_is_tag, out_last and the counter unchanged.
  - out_valid never drops mid-frame.
- Latency: capture edge to first out_valid = 1 cycle. A frame with out_ready held high takes 2*NW cycles.
- Inputs C_IN/T_IN are ignored outside a capture. in_valid while busy (not in the back-to-back slot) is not captured; the producer must hold it.
- Special case WORD_W=128: NW=1, so SEND_C and SEND_T are one word each and out_last coincides with the single tag word.
- Reset mid-frame: immediate return to reset values. The partial frame is dropped and frame_cnt does not increment.
- All outputs are registered except in_ready.

Test Plan:
- Basic frame (WORD_W=32, out_ready=1): capture C_IN=128'h00112233_44556677_8899AABB_CCDDEEFF, T_IN=128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D.
  - Required: 8 consecutive words 00112233, 44556677, 8899AABB, CCDDEEFF, DEADBEEF, 01234567, 89ABCDEF, CAFEF00D.
  - out_is_tag=1 on words 5-8; out_last only on CAFEF00D.
  - frame_cnt=1 and busy=0 one cycle after the last word.
- Backpressure: same frame with out_ready toggling 1,0,0,1,…
  - Required: identical word sequence, out_data stable during every stall, out_valid never deasserts mid-frame.
- Back-to-back: in_valid held high with a second frame C=128'h1, T=128'h2.
  - Required: in_ready=1 exactly in the last-word accept cycle.
  - Next cycle out_data=32'h0000_0000 (first word of the new C) with no bubble; frame_cnt=2 after the 16th word.
- Busy rejection: pulse in_valid for 1 cycle while in SEND_C.
  - Required: no capture, current frame unchanged, frame_cnt increments only once.
- Mid-frame reset: assert RST asynchronously (between edges) after word 3.
  - Required: out_valid, busy and frame_cnt are 0 immediately and in_ready=0.
  - After release, in_ready=1 and a fresh frame streams correctly.
- Frame counter wrap and WORD_W=128:
  - Preload 65535 frames (or force the counter), then send one more frame: frame_cnt wraps to 0.
  - With WORD_W=128: exactly 2 words (C then T), and out_last is set on the T word.
